// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU and response signal bundle for alu_arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 2,
    parameter int CMDW  = 3
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*CMDW-1:0]  req_cmd;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [CMDW-1:0]       alu_cmd;
    logic [WIDTH-1:0]      alu_res;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;

    modport master (
        input  req_valid, req_a, req_b, req_cmd, alu_res, rsp_ready,
        output req_ready, alu_a, alu_b, alu_cmd, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        output req_valid, req_a, req_b, req_cmd, alu_res, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_cmd, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between NREQ requesters
// Optional op_count statistics port enabled by ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 2,
    parameter int CMDW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.master     bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       op_count
`endif
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   next_ptr;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic [IDW:0]     cand;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [CMDW-1:0]  sel_cmd;

    // Scan from rr_ptr upward, wrapping; the first valid index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a   = bus.req_a[i*WIDTH +: WIDTH];
                sel_b   = bus.req_b[i*WIDTH +: WIDTH];
                sel_cmd = bus.req_cmd[i*CMDW +: CMDW];
            end
        end
    end

    assign next_ptr = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

    // Acceptance is suppressed under reset so no handshake completes that the registers drop.
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_found && !rst) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_cmd   <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.alu_a   <= sel_a;
                        bus.alu_b   <= sel_b;
                        bus.alu_cmd <= sel_cmd;
                        bus.rsp_id  <= grant_idx;
                        rr_ptr      <= next_ptr;
                    end
                end
                EXEC: begin
                    bus.rsp_data  <= bus.alu_res;
                    bus.rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a transaction model
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(3), .NREQ(2), .CMDW(3)) bus2 ();
    alu_arbiter_if #(.WIDTH(3), .NREQ(4), .CMDW(3)) bus4 ();

    assign bus2.alu_res = bus2.alu_a + bus2.alu_b;
    assign bus4.alu_res = bus4.alu_a + bus4.alu_b;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_count2;
    logic [15:0] op_count4;
    alu_arbiter #(.WIDTH(3), .NREQ(2), .CMDW(3)) u2 (.clk(clk), .rst(rst), .bus(bus2), .op_count(op_count2));
    alu_arbiter #(.WIDTH(3), .NREQ(4), .CMDW(3)) u4 (.clk(clk), .rst(rst), .bus(bus4), .op_count(op_count4));
`else
    alu_arbiter #(.WIDTH(3), .NREQ(2), .CMDW(3)) u2 (.clk(clk), .rst(rst), .bus(bus2));
    alu_arbiter #(.WIDTH(3), .NREQ(4), .CMDW(3)) u4 (.clk(clk), .rst(rst), .bus(bus4));
`endif

    // Transaction model: one operation outstanding per DUT, response two cycles after grant.
    int ptr   [2];
    bit busy  [2];
    int age   [2];
    int pdata [2];
    int pid   [2];
    int obs_g [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int d, input int n, input logic [3:0] v,
                              input logic [11:0] a, input logic [11:0] b,
                              input logic [3:0] obs_rdy, input logic obs_rv,
                              input logic [2:0] obs_d, input logic [1:0] obs_id,
                              input logic rr);
        logic [3:0] exp_rdy;
        logic       exp_rv;
        int         g;
        exp_rdy = '0;
        g = -1;
        if (!rst && !busy[d]) begin
            for (int k = 0; k < n; k++) begin
                if (g < 0 && v[(ptr[d] + k) % n]) g = (ptr[d] + k) % n;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk($sformatf("u%0d.req_ready", n), {28'd0, obs_rdy}, {28'd0, exp_rdy});
        exp_rv = busy[d] && age[d] >= 2;
        chk($sformatf("u%0d.rsp_valid", n), {31'd0, obs_rv}, {31'd0, exp_rv});
        if (exp_rv) begin
            chk($sformatf("u%0d.rsp_data", n), {29'd0, obs_d}, pdata[d]);
            chk($sformatf("u%0d.rsp_id", n), {30'd0, obs_id}, pid[d]);
        end
        obs_g[d] = -1;
        for (int i = 0; i < 4; i++) if (obs_rdy[i]) obs_g[d] = i;
        if (rst) begin
            busy[d] = 0;
            ptr[d]  = 0;
        end else if (g >= 0) begin
            busy[d]  = 1;
            age[d]   = 1;
            pdata[d] = (int'(a[g*3 +: 3]) + int'(b[g*3 +: 3])) % 8;
            pid[d]   = g;
            ptr[d]   = (g + 1) % n;
        end else if (busy[d]) begin
            if (age[d] >= 2 && rr) busy[d] = 0;
            else age[d]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step(0, 2, {2'b0, bus2.req_valid}, {6'b0, bus2.req_a}, {6'b0, bus2.req_b},
                   {2'b0, bus2.req_ready}, bus2.rsp_valid, bus2.rsp_data, {1'b0, bus2.rsp_id}, bus2.rsp_ready);
        model_step(1, 4, bus4.req_valid, bus4.req_a, bus4.req_b,
                   bus4.req_ready, bus4.rsp_valid, bus4.rsp_data, bus4.rsp_id, bus4.rsp_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic set2(input int i, input int a, input int b, input int c);
        bus2.req_a[i*3 +: 3]   = 3'(a);
        bus2.req_b[i*3 +: 3]   = 3'(b);
        bus2.req_cmd[i*3 +: 3] = 3'(c);
    endtask

    task automatic set4(input int i, input int a, input int b, input int c);
        bus4.req_a[i*3 +: 3]   = 3'(a);
        bus4.req_b[i*3 +: 3]   = 3'(b);
        bus4.req_cmd[i*3 +: 3] = 3'(c);
    endtask

    initial begin
        int grants;
        int prev;
        int held_data;
        int held_id;
        bit pend2 [2];
        bit pend4 [4];

        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0; busy[d] = 0; age[d] = 0; pdata[d] = 0; pid[d] = 0; obs_g[d] = -1;
        end
        bus2.req_valid = '0; bus2.req_a = '0; bus2.req_b = '0; bus2.req_cmd = '0; bus2.rsp_ready = 1'b1;
        bus4.req_valid = '0; bus4.req_a = '0; bus4.req_b = '0; bus4.req_cmd = '0; bus4.rsp_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst.alu_a", {29'd0, bus2.alu_a}, 0);
        chk("rst.alu_b", {29'd0, bus2.alu_b}, 0);
        chk("rst.alu_cmd", {29'd0, bus2.alu_cmd}, 0);
        chk("rst.rsp_data", {29'd0, bus2.rsp_data}, 0);
        chk("rst.rsp_id", {31'd0, bus2.rsp_id}, 0);
`ifdef ALU_ARB_STATS_EN
        chk("rst.op_count", {16'd0, op_count2}, 0);
`endif
        rst = 1'b0;

        // 1. Single operation
        set2(0, 4, 5, 0);
        bus2.req_valid = 2'b01;
        tick();
        chk("t1.grant", obs_g[0], 0);
        bus2.req_valid = 2'b00;
        chk("t1.alu_a", {29'd0, bus2.alu_a}, 4);
        chk("t1.alu_b", {29'd0, bus2.alu_b}, 5);
        chk("t1.alu_cmd", {29'd0, bus2.alu_cmd}, 0);
        tick();
        chk("t1.rsp_valid", {31'd0, bus2.rsp_valid}, 1);
        chk("t1.rsp_data", {29'd0, bus2.rsp_data}, 1);
        chk("t1.rsp_id", {31'd0, bus2.rsp_id}, 0);
        tick();
        tick();

        // 2. Contention: grants must alternate
        set2(0, 1, 2, 1);
        set2(1, 3, 6, 2);
        bus2.req_valid = 2'b11;
        grants = 0;
        prev = -1;
        for (int c = 0; c < 30 && grants < 4; c++) begin
            tick();
            if (obs_g[0] >= 0) begin
                if (grants > 0) chk("t2.alternate", {31'd0, obs_g[0] != prev}, 1);
                prev = obs_g[0];
                grants++;
            end
        end
        chk("t2.grant_count", grants, 4);
        bus2.req_valid = 2'b00;
        for (int c = 0; c < 4; c++) tick();

        // 3. Backpressure
        bus2.rsp_ready = 1'b0;
        set2(0, 6, 7, 4);
        bus2.req_valid = 2'b01;
        tick();
        bus2.req_valid = 2'b10;
        set2(1, 2, 2, 0);
        tick();
        tick();
        held_data = int'(bus2.rsp_data);
        held_id = int'(bus2.rsp_id);
        chk("t3.data", held_data, 5);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3.no_grant", obs_g[0], -1);
        end
        chk("t3.data_stable", {29'd0, bus2.rsp_data}, held_data);
        chk("t3.id_stable", {31'd0, bus2.rsp_id}, held_id);
        bus2.rsp_ready = 1'b1;
        tick();
        tick();
        chk("t3.regrant", obs_g[0], 1);
        bus2.req_valid = 2'b00;
        for (int c = 0; c < 3; c++) tick();

        // 4. Reset during EXEC
        set2(1, 7, 7, 2);
        bus2.req_valid = 2'b10;
        tick();
        bus2.req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4.rsp_valid", {31'd0, bus2.rsp_valid}, 0);
        chk("t4.alu_a", {29'd0, bus2.alu_a}, 0);
        chk("t4.rsp_data", {29'd0, bus2.rsp_data}, 0);
        chk("t4.rsp_id", {31'd0, bus2.rsp_id}, 0);
        for (int c = 0; c < 4; c++) tick();

        // 5. Pointer wrap on NREQ=4
        set4(3, 1, 1, 0);
        bus4.req_valid = 4'b1000;
        tick();
        chk("t5.grant3", obs_g[1], 3);
        bus4.req_valid = 4'b0000;
        for (int c = 0; c < 6; c++) tick();
        set4(0, 2, 3, 0);
        set4(2, 5, 5, 0);
        bus4.req_valid = 4'b0101;
        tick();
        chk("t5.grant0", obs_g[1], 0);
        bus4.req_valid = 4'b0100;
        tick();
        tick();
        chk("t5.rsp_data", {29'd0, bus4.rsp_data}, 5);
        bus4.req_valid = 4'b0000;
        for (int c = 0; c < 4; c++) tick();

        // Randomized traffic on both instances against the model
        for (int i = 0; i < 2; i++) pend2[i] = 0;
        for (int i = 0; i < 4; i++) pend4[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (obs_g[0] == i) pend2[i] = 0;
                if (!pend2[i] && $urandom_range(0, 2) == 0) begin
                    pend2[i] = 1;
                    set2(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                end else if (pend2[i] && $urandom_range(0, 15) == 0) begin
                    pend2[i] = 0;
                end
                bus2.req_valid[i] = pend2[i];
            end
            for (int i = 0; i < 4; i++) begin
                if (obs_g[1] == i) pend4[i] = 0;
                if (!pend4[i] && $urandom_range(0, 3) == 0) begin
                    pend4[i] = 1;
                    set4(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                end else if (pend4[i] && $urandom_range(0, 15) == 0) begin
                    pend4[i] = 0;
                end
                bus4.req_valid[i] = pend4[i];
            end
            bus2.rsp_ready = 1'($urandom_range(0, 1));
            bus4.rsp_ready = 1'($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            rst = 1'b0;
        end

`ifdef ALU_ARB_STATS_EN
        // 6. Completed-operation counter
        bus2.req_valid = 2'b00;
        bus4.req_valid = 4'b0000;
        bus2.rsp_ready = 1'b1;
        bus4.rsp_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set2(0, 3, 3, 0);
        bus2.req_valid = 2'b01;
        for (int c = 0; c < 9; c++) tick();
        bus2.req_valid = 2'b00;
        chk("t6.op_count", {16'd0, op_count2}, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.op_count_rst", {16'd0, op_count2}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
